// File: rtl/coreriscv_axi4_tl_uncached_scratchpad_manager.sv
// Uncached TileLink acquire/grant manager backed by an on-chip 64-bit
// scratchpad. Serves Get, GetBlock, Put and PutBlock. Anything else gets a
// prefetchAck and has no effect on memory.
// Optional build macro CORERISCV_AXI4_TL_OOR_EN adds out-of-range detection
// and the sticky io_oor_error output. Without it, addresses wrap modulo the
// scratchpad depth.
module coreriscv_axi4_tl_uncached_scratchpad_manager #(
   parameter int         DEPTH_LOG2  = 10,
   parameter logic [1:0] MGR_XACT_ID = 2'd0
) (
   input  logic        clk,
   input  logic        reset,
   output logic        io_acquire_ready,
   input  logic        io_acquire_valid,
   input  logic [25:0] io_acquire_bits_addr_block,
   input  logic        io_acquire_bits_client_xact_id,
   input  logic [2:0]  io_acquire_bits_addr_beat,
   input  logic        io_acquire_bits_is_builtin_type,
   input  logic [2:0]  io_acquire_bits_a_type,
   input  logic [11:0] io_acquire_bits_union,
   input  logic [63:0] io_acquire_bits_data,
   input  logic        io_grant_ready,
   output logic        io_grant_valid,
   output logic [2:0]  io_grant_bits_addr_beat,
   output logic        io_grant_bits_client_xact_id,
   output logic [1:0]  io_grant_bits_manager_xact_id,
   output logic        io_grant_bits_is_builtin_type,
   output logic [3:0]  io_grant_bits_g_type,
   output logic [63:0] io_grant_bits_data
`ifdef CORERISCV_AXI4_TL_OOR_EN
   ,
   output logic        io_oor_error
`endif
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_ACK} state_t;

   state_t state_q, state_d;

   logic [2:0]  cnt_q;
   logic        block_q;
   logic [3:0]  gtype_q;
   logic        xact_q;
   logic [25:0] blk_q;

   logic [63:0] mem [0:DEPTH-1];
   logic [63:0] rd_data_p1;

   logic                  rd_en, wr_en;
   logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;

   logic acq_fire, gnt_fire;
   logic is_get, is_getblk, is_put, is_putblk;
   logic drop_wr, zero_rd;

   logic [2:0]  cnt_nxt;
   logic [28:0] acq_full, acq_blk0_full, rd_blk_full, wr_blk_full;

   assign acq_fire = io_acquire_valid && io_acquire_ready;
   assign gnt_fire = io_grant_valid && io_grant_ready;

   assign is_get    = io_acquire_bits_is_builtin_type && (io_acquire_bits_a_type == 3'd0);
   assign is_getblk = io_acquire_bits_is_builtin_type && (io_acquire_bits_a_type == 3'd1);
   assign is_put    = io_acquire_bits_is_builtin_type && (io_acquire_bits_a_type == 3'd2);
   assign is_putblk = io_acquire_bits_is_builtin_type && (io_acquire_bits_a_type == 3'd3);

   assign cnt_nxt       = cnt_q + 3'd1;
   assign acq_full      = {io_acquire_bits_addr_block, io_acquire_bits_addr_beat};
   assign acq_blk0_full = {io_acquire_bits_addr_block, 3'd0};
   assign rd_blk_full   = {blk_q, cnt_nxt};
   assign wr_blk_full   = {blk_q, io_acquire_bits_addr_beat};

`ifdef CORERISCV_AXI4_TL_OOR_EN
   logic acq_oor, oor_q;

   // Block bits beyond the scratchpad span mark the access as out of range
   assign acq_oor = |(io_acquire_bits_addr_block >> (DEPTH_LOG2 - 3));
   assign drop_wr = (state_q == S_IDLE) ? acq_oor : oor_q;
   assign zero_rd = oor_q;

   // Range flag of the current transaction and the sticky error output
   always_ff @(posedge clk) begin
      if (!reset) begin
         oor_q        <= 1'b0;
         io_oor_error <= 1'b0;
      end else begin
         if (acq_fire && state_q == S_IDLE) oor_q <= acq_oor;
         if (acq_fire && acq_oor) io_oor_error <= 1'b1;
      end
   end
`else
   assign drop_wr = 1'b0;
   assign zero_rd = 1'b0;
`endif

   // Address bits above the scratchpad index and the alloc/unused union bits
   logic unused_sink;
   assign unused_sink = ^{acq_full, acq_blk0_full, rd_blk_full, wr_blk_full,
                          io_acquire_bits_union[11:9], io_acquire_bits_union[0]};

   // Next state plus memory read/write strobes
   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      rd_idx  = acq_full[DEPTH_LOG2-1:0];
      wr_idx  = acq_full[DEPTH_LOG2-1:0];
      case (state_q)
         S_IDLE: begin
            if (acq_fire) begin
               if (is_get) begin
                  rd_en   = 1'b1;
                  state_d = S_READ;
               end else if (is_getblk) begin
                  rd_en   = 1'b1;
                  rd_idx  = acq_blk0_full[DEPTH_LOG2-1:0];
                  state_d = S_READ;
               end else if (is_put) begin
                  wr_en   = !drop_wr;
                  state_d = S_ACK;
               end else if (is_putblk) begin
                  wr_en   = !drop_wr;
                  state_d = S_WRITE;
               end else begin
                  state_d = S_ACK;
               end
            end
         end
         S_READ: begin
            if (gnt_fire) begin
               if (!block_q || cnt_q == 3'd7) begin
                  state_d = S_IDLE;
               end else begin
                  // Prefetch the next beat so a ready client sees no bubble
                  rd_en  = 1'b1;
                  rd_idx = rd_blk_full[DEPTH_LOG2-1:0];
               end
            end
         end
         S_WRITE: begin
            if (acq_fire) begin
               wr_en  = !drop_wr;
               wr_idx = wr_blk_full[DEPTH_LOG2-1:0];
               if (cnt_q == 3'd7) state_d = S_ACK;
            end
         end
         S_ACK: begin
            if (gnt_fire) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control registers: state, beat counter, grant type, block mode
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         block_q <= 1'b0;
         gtype_q <= 4'd0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && acq_fire) begin
            block_q <= is_getblk;
            if (is_get)         cnt_q <= io_acquire_bits_addr_beat;
            else if (is_putblk) cnt_q <= 3'd1;
            else                cnt_q <= 3'd0;
            if (is_get)                      gtype_q <= 4'd3;
            else if (is_getblk)              gtype_q <= 4'd4;
            else if (is_put || is_putblk)    gtype_q <= 4'd2;
            else                             gtype_q <= 4'd1;
         end else if (state_q == S_READ && gnt_fire && block_q && cnt_q != 3'd7) begin
            cnt_q <= cnt_nxt;
         end else if (state_q == S_WRITE && acq_fire) begin
            cnt_q <= cnt_nxt;
         end
      end
   end

   // Transaction identity captured at the opening acquire
   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && acq_fire) begin
         xact_q <= io_acquire_bits_client_xact_id;
         blk_q  <= io_acquire_bits_addr_block;
      end
   end

   // Scratchpad: byte-masked write port, registered read port
   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (wr_en && io_acquire_bits_union[i+1])
            mem[wr_idx][8*i +: 8] <= io_acquire_bits_data[8*i +: 8];
      end
      if (rd_en) rd_data_p1 <= mem[rd_idx];
   end

   // Handshake and grant outputs; grant fields are zero whenever not valid
   always_comb begin
      io_acquire_ready              = reset && (state_q == S_IDLE || state_q == S_WRITE);
      io_grant_valid                = reset && (state_q == S_READ || state_q == S_ACK);
      io_grant_bits_addr_beat       = 3'd0;
      io_grant_bits_client_xact_id  = 1'b0;
      io_grant_bits_manager_xact_id = 2'd0;
      io_grant_bits_is_builtin_type = 1'b0;
      io_grant_bits_g_type          = 4'd0;
      io_grant_bits_data            = 64'd0;
      if (io_grant_valid) begin
         io_grant_bits_client_xact_id  = xact_q;
         io_grant_bits_manager_xact_id = MGR_XACT_ID;
         io_grant_bits_is_builtin_type = 1'b1;
         io_grant_bits_g_type          = gtype_q;
         if (state_q == S_READ) begin
            io_grant_bits_addr_beat = cnt_q;
            io_grant_bits_data      = zero_rd ? 64'd0 : rd_data_p1;
         end
      end
   end

endmodule
